instruction_encoder: RTL

Packs decoded RISC-V RV32I instruction fields plus a 32-bit immediate into 32-bit instruction words. It performs the inverse of the core's immediate generator: it range-checks the immediate for the opcode's format and scatters its bits into the I/S/B/U/J layouts. An out-of-range ADDI-from-x0 (load-immediate) expands into a LUI + ADDI pair. It sits between the test-program sequencer and the instruction-memory writer, with valid/ready handshakes on both sides and one registered output stage.

---
 rtl/instruction_encoder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs decoded RV32I fields plus a 32-bit immediate into
// instruction words, range-checking the immediate for the opcode's format and
// expanding an out-of-range load-immediate (ADDI rd, x0, imm) into LUI + ADDI.
module instruction_encoder (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_error,
  output logic        out_last
);

  localparam int unsigned INST_W = 32;
  localparam int unsigned OPC_W  = 7;
  localparam int unsigned HI_W   = 20;
  localparam int unsigned LO_W   = 12;

  // Major opcodes (RV32I base plus FP load/store)
  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'h03;
  localparam logic [OPC_W-1:0] OPC_LOAD_FP  = 7'h07;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'h13;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'h17;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'h23;
  localparam logic [OPC_W-1:0] OPC_STORE_FP = 7'h27;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'h33;
  localparam logic [OPC_W-1:0] OPC_LUI      = 7'h37;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'h63;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'h67;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'h6F;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FINAL = 2'd1,
    ST_FIRST = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [INST_W-1:0]   pend_q, pend_d;
  logic                valid_d, error_d, last_d;
  logic [INST_W-1:0]   inst_d;

  logic                i_ok, b_ok, j_ok, u_ok, sh_ok;
  logic                is_shift;
  logic [HI_W-1:0]     li_hi;
  logic [LO_W-1:0]     li_lo;

  logic [INST_W-1:0]   enc_inst;
  logic [INST_W-1:0]   enc_addi;
  logic                enc_err;
  logic                enc_two;
  logic                accept, fire, load_new;

  // Immediate range checks: sign-extension bits must all agree, alignment as required
  assign i_ok  = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign b_ok  = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign j_ok  = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];
  assign u_ok  = ~(|in_imm[11:0]);
  assign sh_ok = ~(|in_imm[31:5]);
  assign is_shift = (in_funct3 == 3'b001) || (in_funct3 == 3'b101);

  // LUI upper part compensates for the sign of the ADDI lower part
  assign li_hi = in_imm[31:12] + HI_W'(in_imm[11]);
  assign li_lo = in_imm[11:0];

  // Field scatter for the incoming instruction, plus the pending ADDI of an expansion
  always_comb begin
    enc_inst = '0;
    enc_addi = '0;
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    case (in_opcode)
      OPC_LOAD, OPC_LOAD_FP, OPC_JALR: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        enc_err  = ~i_ok;
      end
      OPC_OP_IMM: begin
        if (is_shift) begin
          enc_inst = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err  = ~sh_ok;
        end else if ((in_funct3 == 3'b000) && (in_rs1 == 5'd0) && !i_ok) begin
          enc_inst = {li_hi, in_rd, OPC_LUI};
          enc_addi = {li_lo, in_rd, 3'b000, in_rd, OPC_OP_IMM};
          enc_two  = (li_lo != '0);
        end else begin
          enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          enc_err  = ~i_ok;
        end
      end
      OPC_STORE, OPC_STORE_FP: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        enc_err  = ~i_ok;
      end
      OPC_BRANCH: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        enc_err  = ~b_ok;
      end
      OPC_LUI, OPC_AUIPC: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        enc_err  = ~u_ok;
      end
      OPC_JAL: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        enc_err  = ~j_ok;
      end
      OPC_OP: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      default: begin
        enc_inst = '0;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Next-state and output-register logic for the single output stage
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    valid_d  = out_valid;
    inst_d   = out_inst;
    error_d  = out_error;
    last_d   = out_last;
    load_new = 1'b0;

    in_ready = (state_q == ST_EMPTY) || ((state_q == ST_FINAL) && out_ready);
    accept   = in_valid && in_ready;
    fire     = out_valid && out_ready;

    case (state_q)
      ST_EMPTY: begin
        load_new = accept;
      end
      ST_FIRST: begin
        if (fire) begin
          state_d = ST_FINAL;
          inst_d  = pend_q;
          error_d = 1'b0;
          last_d  = 1'b1;
          pend_d  = '0;
        end
      end
      ST_FINAL: begin
        if (fire) begin
          if (accept) begin
            load_new = 1'b1;
          end else begin
            state_d = ST_EMPTY;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_EMPTY;
        valid_d = 1'b0;
      end
    endcase

    if (load_new) begin
      valid_d = 1'b1;
      inst_d  = enc_inst;
      error_d = enc_err;
      last_d  = ~enc_two;
      pend_d  = enc_two ? enc_addi : '0;
      state_d = enc_two ? ST_FIRST : ST_FINAL;
    end
  end

  // State, pending ADDI and registered outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_EMPTY;
      pend_q    <= '0;
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_error <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      out_valid <= valid_d;
      out_inst  <= inst_d;
      out_error <= error_d;
      out_last  <= last_d;
    end
  end

endmodule
